// File: rtl/qdec_updown_counter_if.sv
// Pin bundle between a quadrature phase source and the decoder/counter.
// The master drives phases and controls; the slave returns the registered position and status.
interface qdec_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             clr;
    logic             a_in;
    logic             b_in;
    logic             idx_in;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             wrap;
    logic             err;

    modport master (
        output en, clr, a_in, b_in, idx_in,
        input  count, dir, step, wrap, err
    );

    modport slave (
        input  en, clr, a_in, b_in, idx_in,
        output count, dir, step, wrap, err
    );
endinterface

// File: rtl/qdec_updown_counter.sv
// Quadrature decoder with a wrapping up/down position counter, synchronous to clk.
// Optional index-pulse clear is compiled in when QDEC_INDEX_EN is defined.
module qdec_updown_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  rst,
    qdec_updown_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [SYNC_STAGES-1:0] vld_sync;
    logic [1:0]             ab_s;
    logic [1:0]             ab_p;
    logic                   primed;
    logic [WIDTH-1:0]       count_q;
    logic                   dir_q;
    logic                   step_q;
    logic                   wrap_q;
    logic                   err_q;
    logic                   moved;
    logic                   illegal;
    logic                   up;
    logic                   idx_rise;

    assign ab_s = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    // vld_sync tracks which synchroniser stages hold real samples rather than
    // reset zeros, so priming never compares against a stale 00.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync   <= '0;
            b_sync   <= '0;
            vld_sync <= '0;
        end else begin
            a_sync   <= {a_sync[SYNC_STAGES-2:0], bus.a_in};
            b_sync   <= {b_sync[SYNC_STAGES-2:0], bus.b_in};
            vld_sync <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

`ifdef QDEC_INDEX_EN
    logic [SYNC_STAGES-1:0] idx_sync;
    logic                   idx_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_sync <= '0;
            idx_p    <= 1'b0;
        end else begin
            idx_sync <= {idx_sync[SYNC_STAGES-2:0], bus.idx_in};
            idx_p    <= idx_sync[SYNC_STAGES-1];
        end
    end

    assign idx_rise = idx_sync[SYNC_STAGES-1] & ~idx_p;
`else
    logic unused_idx;
    assign unused_idx = bus.idx_in;
    assign idx_rise   = 1'b0;
`endif

    // Moving A to differ from the old B is the A-leads (up) direction.
    assign up = ab_s[1] ^ ab_p[0];

    always_comb begin
        moved   = 1'b0;
        illegal = 1'b0;
        if (primed && (ab_s != ab_p)) begin
            if ((ab_s[1] != ab_p[1]) && (ab_s[0] != ab_p[0])) begin
                illegal = 1'b1;
            end else begin
                moved = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ab_p    <= 2'b00;
            primed  <= 1'b0;
            count_q <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ab_p   <= ab_s;
            primed <= vld_sync[SYNC_STAGES-1];
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            if (bus.clr) begin
                count_q <= '0;
                err_q   <= 1'b0;
            end else begin
                if (bus.en && illegal) begin
                    err_q <= 1'b1;
                end
                if (idx_rise) begin
                    count_q <= '0;
                end else if (bus.en && moved) begin
                    dir_q  <= up;
                    step_q <= 1'b1;
                    if (up) begin
                        count_q <= count_q + ONE;
                        wrap_q  <= (count_q == '1);
                    end else begin
                        count_q <= count_q - ONE;
                        wrap_q  <= (count_q == '0);
                    end
                end
            end
        end
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.step  = step_q;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_qdec_updown_counter.sv
// Bench for qdec_updown_counter: directed vector table, hand sequences for latency,
// clear/reset/index corners, and random phase traffic against a history-based model.
module tb_qdec_updown_counter;
    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic clk = 1'b0;
    logic rst;

    qdec_updown_counter_if #(.WIDTH(W)) bus ();

    qdec_updown_counter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the falling edge; outputs are read there too.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    function automatic int gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_ab(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic set_pos(input int p);
        logic [1:0] ab;
        ab       = gray_ab(p);
        bus.a_in = ab[1];
        bus.b_in = ab[0];
    endtask

    // Reference model: keeps the raw per-edge samples since reset. The sample taken
    // two edges ago is the newly seen phase pair, three edges ago the previous one.
    logic [1:0]   hist[$];
    logic         idx_hist[$];
    logic [W+3:0] exp_q[$];
    int           m_count;
    logic         m_dir, m_err, m_step, m_wrap, m_illegal, m_idx;
    int           m_n, m_mv, m_d, m_next;

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            idx_hist.delete();
            exp_q.delete();
            m_count = 0;
            m_dir   = 1'b1;
            m_err   = 1'b0;
        end else begin
            hist.push_back({bus.a_in, bus.b_in});
            idx_hist.push_back(bus.idx_in);
            if (hist.size() > 6) begin
                void'(hist.pop_front());
                void'(idx_hist.pop_front());
            end
            m_n       = hist.size();
            m_mv      = 0;
            m_illegal = 1'b0;
            m_step    = 1'b0;
            m_wrap    = 1'b0;
            m_idx     = 1'b0;
            if (m_n >= 4) begin
                m_d = (gray_pos(hist[m_n-3]) - gray_pos(hist[m_n-4]) + 4) % 4;
                if (m_d == 1) m_mv = 1;
                else if (m_d == 3) m_mv = -1;
                else if (m_d == 2) m_illegal = 1'b1;
            end
`ifdef QDEC_INDEX_EN
            if (m_n >= 3) m_idx = idx_hist[m_n-3] && !(m_n >= 4 && idx_hist[m_n-4]);
`endif
            if (bus.clr) begin
                m_count = 0;
                m_err   = 1'b0;
            end else begin
                if (bus.en && m_illegal) m_err = 1'b1;
                if (m_idx) begin
                    m_count = 0;
                end else if (bus.en && m_mv != 0) begin
                    m_next  = m_count + m_mv;
                    m_dir   = (m_mv > 0);
                    m_step  = 1'b1;
                    m_wrap  = (m_next < 0) || (m_next >= MOD);
                    m_count = (m_next + MOD) % MOD;
                end
            end
            exp_q.push_back({W'(m_count), m_dir, m_step, m_wrap, m_err});
        end
    end

    logic [W+3:0] e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("model_count", 32'(bus.count), 32'(e[W+3:4]));
            check("model_dir",   32'(bus.dir),   32'(e[3]));
            check("model_step",  32'(bus.step),  32'(e[2]));
            check("model_wrap",  32'(bus.wrap),  32'(e[1]));
            check("model_err",   32'(bus.err),   32'(e[0]));
        end
    end

    typedef struct {
        logic a, b, en, clr;
        int   exp_count, exp_dir, exp_err, exp_steps, exp_wraps;
    } vec_t;

    vec_t vecs[20];
    int   steps, wraps, cur;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0,   1, 1, 0, 1, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0,   2, 1, 0, 1, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0,   3, 1, 0, 1, 0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0,   4, 1, 0, 1, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0,   5, 1, 0, 1, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0,   6, 1, 0, 1, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0,   7, 1, 0, 1, 0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0,   8, 1, 0, 1, 0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1,   0, 1, 0, 0, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 255, 0, 0, 1, 1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0,   0, 1, 0, 1, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0,   0, 1, 1, 0, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0,   1, 1, 1, 1, 0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1,   0, 1, 0, 0, 0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0,   0, 1, 0, 0, 0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0,   0, 1, 0, 0, 0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0,   0, 1, 0, 0, 0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0,   1, 1, 0, 1, 0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 1, 0, 0, 0};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0,   2, 1, 0, 1, 0};

        // Reset with both phases high, then prime.
        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.clr    = 1'b0;
        bus.a_in   = 1'b1;
        bus.b_in   = 1'b1;
        bus.idx_in = 1'b0;
        cyc(3);
        rst = 1'b0;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_dir",   32'(bus.dir),   32'd1);
        check("rst_err",   32'(bus.err),   32'd0);
        steps = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            steps += int'(bus.step) + int'(bus.err);
        end
        check("prime_no_step_no_err", 32'(steps), 32'd0);

        // Directed vector table, 8 clocks per entry.
        for (int v = 0; v < 20; v++) begin
            bus.a_in = vecs[v].a;
            bus.b_in = vecs[v].b;
            bus.en   = vecs[v].en;
            bus.clr  = vecs[v].clr;
            steps = 0;
            wraps = 0;
            for (int c = 0; c < 8; c++) begin
                cyc(1);
                steps += int'(bus.step);
                wraps += int'(bus.wrap);
            end
            check($sformatf("vec%0d_count", v), 32'(bus.count), 32'(vecs[v].exp_count));
            check($sformatf("vec%0d_dir", v),   32'(bus.dir),   32'(vecs[v].exp_dir));
            check($sformatf("vec%0d_err", v),   32'(bus.err),   32'(vecs[v].exp_err));
            check($sformatf("vec%0d_steps", v), 32'(steps),     32'(vecs[v].exp_steps));
            check($sformatf("vec%0d_wraps", v), 32'(wraps),     32'(vecs[v].exp_wraps));
        end
        bus.clr = 1'b0;
        bus.en  = 1'b1;

        // Latency: 00 -> 10 with count 2 lands on the third sample after the change.
        set_pos(1);
        cyc(1); check("lat_step_c1", 32'(bus.step), 32'd0);
        cyc(1); check("lat_step_c2", 32'(bus.step), 32'd0);
        check("lat_count_c2", 32'(bus.count), 32'd2);
        cyc(1); check("lat_step_c3", 32'(bus.step), 32'd1);
        check("lat_count_c3", 32'(bus.count), 32'd3);
        cyc(1); check("lat_step_c4", 32'(bus.step), 32'd0);
        cyc(4);

        // Clear landing on the same edge as a decoded step wins.
        set_pos(2);
        cyc(2);
        bus.clr = 1'b1;
        cyc(1);
        bus.clr = 1'b0;
        check("clr_coll_count", 32'(bus.count), 32'd0);
        check("clr_coll_step",  32'(bus.step),  32'd0);
        cyc(4);
        check("clr_coll_after", 32'(bus.count), 32'd0);

        // Reset mid-step discards the in-flight transition.
        set_pos(3);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst   = 1'b0;
        steps = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(1);
            steps += int'(bus.step);
        end
        check("midrst_steps", 32'(steps),     32'd0);
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_err",   32'(bus.err),   32'd0);

        // Random phase traffic, checked each cycle by the model.
        for (int i = 0; i < 400; i++) begin
            cur = gray_pos({bus.a_in, bus.b_in});
            case ($urandom_range(0, 9))
                0, 1, 2, 3: set_pos(cur + 1);
                4, 5, 6:    set_pos(cur + 3);
                7:          set_pos(cur + 2);
                default:    set_pos(cur);
            endcase
            bus.en     = ($urandom_range(0, 9) != 0);
            bus.clr    = ($urandom_range(0, 39) == 0);
            bus.idx_in = ($urandom_range(0, 19) == 0);
            cyc($urandom_range(1, 4));
        end

        // Index: reach 37, then pulse idx_in for 4 clocks.
        bus.en     = 1'b1;
        bus.idx_in = 1'b0;
        bus.clr    = 1'b1;
        cyc(4);
        bus.clr = 1'b0;
        cyc(1);
        for (int i = 0; i < 37; i++) begin
            set_pos(gray_pos({bus.a_in, bus.b_in}) + 1);
            cyc(4);
        end
        check("idx_pre_count", 32'(bus.count), 32'd37);
        bus.idx_in = 1'b1;
        wraps      = 0;
        cyc(1); wraps += int'(bus.wrap);
        cyc(1); wraps += int'(bus.wrap);
        check("idx_count_c2", 32'(bus.count), 32'd37);
        cyc(1); wraps += int'(bus.wrap);
`ifdef QDEC_INDEX_EN
        check("idx_count_c3", 32'(bus.count), 32'd0);
`else
        check("idx_count_c3", 32'(bus.count), 32'd37);
`endif
        cyc(1);
        bus.idx_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc(1);
            wraps += int'(bus.wrap);
        end
        check("idx_no_wrap", 32'(wraps), 32'd0);
`ifdef QDEC_INDEX_EN
        check("idx_count_end", 32'(bus.count), 32'd0);
`else
        check("idx_count_end", 32'(bus.count), 32'd37);
`endif
        check("idx_err", 32'(bus.err), 32'd0);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
